// File: rtl/uart_host_mux_if.sv
// Bundles the host-side connection to NUM_CH UART controllers.
// Carries no logic and adds no latency.
// No backpressure: write and read are one-cycle strobes; irq is a level.
interface uart_host_mux_if #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 8
);
   logic [NUM_CH-1:0]        nic_irq;
   logic [NUM_CH*DATA_W-1:0] nic_data_in;
   logic [NUM_CH-1:0]        nic_write;
   logic [NUM_CH*DATA_W-1:0] nic_data_out;
   logic [NUM_CH-1:0]        nic_read;

   // The sequencer drives the strobes and write data.
   modport master (
      input  nic_irq,
      input  nic_data_in,
      output nic_write,
      output nic_data_out,
      output nic_read
   );

   // The UART controllers drive the interrupt and received data.
   modport slave (
      output nic_irq,
      output nic_data_in,
      input  nic_write,
      input  nic_data_out,
      input  nic_read
   );
endinterface

// File: rtl/uart_host_mux.sv
// Per-channel TX queueing with frame pacing, RX interrupt service, counters and loopback check.
// Latency: send to nic_write is 2 edges on an idle channel; irq to nic_read is 1 edge.
// Backpressure: a full queue or an invalid channel drops the byte and pulses send_drop.
module uart_host_mux #(
   parameter int NUM_CH       = 2,
   parameter int DATA_W       = 8,
   parameter int TXQ_DEPTH    = 4,
   parameter int FRAME_CYCLES = 52080,
   parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                send,
   input  logic [DATA_W-1:0]   send_data,
   input  logic [CH_W-1:0]     send_ch,
   input  logic                loopback_chk,
   uart_host_mux_if.master     nic,
   output logic                send_drop,
   output logic [DATA_W-1:0]   last_rx_data,
   output logic [CH_W-1:0]     last_rx_ch,
   output logic [NUM_CH*4-1:0] tx_count,
   output logic [NUM_CH*4-1:0] rx_count,
   output logic [NUM_CH-1:0]   mismatch
);
   localparam int PTR_W = $clog2(TXQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int FC_W  = $clog2(FRAME_CYCLES);

   typedef enum logic [1:0] {TX_IDLE, TX_ISSUE, TX_GAP} tx_state_t;
   typedef enum logic       {RX_WAIT, RX_HOLD}          rx_state_t;

   tx_state_t         tx_state     [NUM_CH];
   tx_state_t         tx_state_nxt [NUM_CH];
   logic [FC_W-1:0]   gap_cnt      [NUM_CH];
   logic [FC_W-1:0]   gap_cnt_nxt  [NUM_CH];
   rx_state_t         rx_state     [NUM_CH];
   rx_state_t         rx_state_nxt [NUM_CH];

   logic [DATA_W-1:0] q_mem   [NUM_CH][TXQ_DEPTH];
   logic [PTR_W-1:0]  wr_ptr  [NUM_CH];
   logic [PTR_W-1:0]  rd_ptr  [NUM_CH];
   logic [CNT_W-1:0]  q_cnt   [NUM_CH];
   logic [DATA_W-1:0] tx_dat  [NUM_CH];
   logic [DATA_W-1:0] last_tx [NUM_CH];
   logic [3:0]        tx_cnt  [NUM_CH];
   logic [3:0]        rx_cnt  [NUM_CH];
   logic [NUM_CH-1:0] tx_seen;

   logic [CH_W:0]     send_ch_ext;
   logic              ch_ok;
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] pop;
   logic [NUM_CH-1:0] cap;
   logic [CH_W-1:0]   cap_idx;
   logic [DATA_W-1:0] cap_dat;

   // Push/pop decode; fullness uses pre-edge occupancy so a same-cycle pop never makes room.
   always_comb begin
      send_ch_ext = {1'b0, send_ch};
      ch_ok       = send_ch_ext < (CH_W+1)'(NUM_CH);
      push        = '0;
      pop         = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (send && ch_ok && (send_ch_ext == (CH_W+1)'(i)) && (q_cnt[i] != CNT_W'(TXQ_DEPTH)))
            push[i] = 1'b1;
         pop[i] = (tx_state[i] == TX_ISSUE);
      end
   end

   // Queue payload storage; contents are don't-care while the occupancy says empty.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++)
         if (push[i]) q_mem[i][wr_ptr[i]] <= send_data;
   end

   // Queue pointers, occupancy and the drop pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            q_cnt[i]  <= '0;
         end
         send_drop <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            q_cnt[i] <= q_cnt[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
         end
         send_drop <= send && (push == '0);
      end
   end

   // TX next state: ISSUE, GAP for FRAME_CYCLES-2 cycles, one IDLE cycle => FRAME_CYCLES spacing.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         tx_state_nxt[i] = tx_state[i];
         gap_cnt_nxt[i]  = gap_cnt[i];
         case (tx_state[i])
            TX_IDLE:  if (q_cnt[i] != '0) tx_state_nxt[i] = TX_ISSUE;
            TX_ISSUE: begin
               // A two-cycle frame leaves no room for a gap cycle at all.
               if (FRAME_CYCLES == 2) begin
                  tx_state_nxt[i] = TX_IDLE;
               end else begin
                  tx_state_nxt[i] = TX_GAP;
                  gap_cnt_nxt[i]  = FC_W'(FRAME_CYCLES - 2);
               end
            end
            TX_GAP: begin
               gap_cnt_nxt[i] = gap_cnt[i] - FC_W'(1);
               if (gap_cnt[i] <= FC_W'(1)) begin
                  tx_state_nxt[i] = TX_IDLE;
                  gap_cnt_nxt[i]  = '0;
               end
            end
            default: begin
               tx_state_nxt[i] = TX_IDLE;
               gap_cnt_nxt[i]  = '0;
            end
         endcase
      end
   end

   // TX state, write-data holding register, counters and last written byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            tx_state[i] <= TX_IDLE;
            gap_cnt[i]  <= '0;
            tx_dat[i]   <= '0;
            last_tx[i]  <= '0;
            tx_cnt[i]   <= '0;
         end
         tx_seen <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            tx_state[i] <= tx_state_nxt[i];
            gap_cnt[i]  <= gap_cnt_nxt[i];
            // Load the head as ISSUE is entered; it then holds until the next write.
            if ((tx_state[i] == TX_IDLE) && (q_cnt[i] != '0))
               tx_dat[i] <= q_mem[i][rd_ptr[i]];
            if (tx_state[i] == TX_ISSUE) begin
               tx_cnt[i]  <= tx_cnt[i] + 4'd1;
               last_tx[i] <= tx_dat[i];
               tx_seen[i] <= 1'b1;
            end
         end
      end
   end

   // RX next state and capture select; lowest channel wins the shared display registers.
   always_comb begin
      cap     = '0;
      cap_idx = '0;
      cap_dat = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         rx_state_nxt[i] = RX_WAIT;
         if ((rx_state[i] == RX_WAIT) && nic.nic_irq[i]) begin
            rx_state_nxt[i] = RX_HOLD;
            cap[i]          = 1'b1;
         end
      end
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (cap[i]) begin
            cap_idx = CH_W'(i);
            cap_dat = nic.nic_data_in[i*DATA_W +: DATA_W];
         end
      end
   end

   // RX state, capture registers, counters and sticky loopback mismatch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            rx_state[i] <= RX_WAIT;
            rx_cnt[i]   <= '0;
         end
         last_rx_data <= '0;
         last_rx_ch   <= '0;
         mismatch     <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            rx_state[i] <= rx_state_nxt[i];
            if (cap[i]) begin
               rx_cnt[i] <= rx_cnt[i] + 4'd1;
               if (loopback_chk && (!tx_seen[i] ||
                   (nic.nic_data_in[i*DATA_W +: DATA_W] != last_tx[i])))
                  mismatch[i] <= 1'b1;
            end
         end
         if (cap != '0) begin
            last_rx_data <= cap_dat;
            last_rx_ch   <= cap_idx;
         end
      end
   end

   // Strobes follow the FSM states; buses are packed from the per-channel registers.
   always_comb begin
      nic.nic_write    = '0;
      nic.nic_read     = '0;
      nic.nic_data_out = '0;
      tx_count         = '0;
      rx_count         = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         nic.nic_write[i]                      = (tx_state[i] == TX_ISSUE);
         nic.nic_read[i]                       = (rx_state[i] == RX_HOLD);
         nic.nic_data_out[i*DATA_W +: DATA_W]  = tx_dat[i];
         tx_count[i*4 +: 4]                    = tx_cnt[i];
         rx_count[i*4 +: 4]                    = rx_cnt[i];
      end
   end
endmodule

// File: tb/tb_uart_host_mux.sv
// Directed bench for uart_host_mux: reset, TX pacing and drops, RX service, loopback, wrap.
// A second small instance with three channels covers the out-of-range channel drop.
// Outputs are sampled 1 ns after the falling edge; inputs change at the same point.
module tb_uart_host_mux;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Two-channel instance
   logic       send = 1'b0;
   logic [7:0] send_data = '0;
   logic       send_ch = 1'b0;
   logic       loopback_chk = 1'b0;
   logic       send_drop;
   logic [7:0] last_rx_data;
   logic       last_rx_ch;
   logic [7:0] tx_count;
   logic [7:0] rx_count;
   logic [1:0] mismatch;
   uart_host_mux_if #(.NUM_CH(2), .DATA_W(8)) bus ();

   uart_host_mux #(.NUM_CH(2), .DATA_W(8), .TXQ_DEPTH(4), .FRAME_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .send(send), .send_data(send_data), .send_ch(send_ch),
      .loopback_chk(loopback_chk), .nic(bus.master), .send_drop(send_drop),
      .last_rx_data(last_rx_data), .last_rx_ch(last_rx_ch), .tx_count(tx_count),
      .rx_count(rx_count), .mismatch(mismatch));

   // Three-channel instance: send_ch is 2 bits so channel 3 is representable and invalid
   logic        send3 = 1'b0;
   logic [1:0]  send3_ch = '0;
   logic        drop3;
   logic [7:0]  last_rx_data3;
   logic [1:0]  last_rx_ch3;
   logic [11:0] tx_count3;
   logic [11:0] rx_count3;
   logic [2:0]  mismatch3;
   uart_host_mux_if #(.NUM_CH(3), .DATA_W(8)) bus3 ();

   uart_host_mux #(.NUM_CH(3), .DATA_W(8), .TXQ_DEPTH(4), .FRAME_CYCLES(16)) dut3 (
      .clk(clk), .rst_n(rst_n), .send(send3), .send_data(8'h5A), .send_ch(send3_ch),
      .loopback_chk(1'b0), .nic(bus3.master), .send_drop(drop3),
      .last_rx_data(last_rx_data3), .last_rx_ch(last_rx_ch3), .tx_count(tx_count3),
      .rx_count(rx_count3), .mismatch(mismatch3));

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;
   int rd_cnt [2] = '{0, 0};
   int wr_cyc [$];
   int wr_ch  [$];
   int wr_dat [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Log every write strobe and count read strobes per channel.
   always @(negedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (bus.nic_write[c]) begin
            wr_cyc.push_back(cyc);
            wr_ch.push_back(c);
            wr_dat.push_back(int'(bus.nic_data_out[c*8 +: 8]));
         end
         if (bus.nic_read[c]) rd_cnt[c] = rd_cnt[c] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_send(input logic ch, input logic [7:0] dat);
      send      = 1'b1;
      send_ch   = ch;
      send_data = dat;
      tick(1);
      send = 1'b0;
   endtask

   task automatic rx_byte(input int ch, input logic [7:0] dat);
      bus.nic_data_in[ch*8 +: 8] = dat;
      bus.nic_irq[ch]            = 1'b1;
      tick(1);
      bus.nic_irq[ch]            = 1'b0;
      tick(1);
   endtask

   task automatic log_clear();
      wr_cyc.delete();
      wr_ch.delete();
      wr_dat.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_write"},  32'(bus.nic_write), 0);
      chk({tag, "_read"},   32'(bus.nic_read), 0);
      chk({tag, "_dout"},   32'(bus.nic_data_out), 0);
      chk({tag, "_drop"},   32'(send_drop), 0);
      chk({tag, "_rxdat"},  32'(last_rx_data), 0);
      chk({tag, "_rxch"},   32'(last_rx_ch), 0);
      chk({tag, "_txcnt"},  32'(tx_count), 0);
      chk({tag, "_rxcnt"},  32'(rx_count), 0);
      chk({tag, "_mism"},   32'(mismatch), 0);
   endtask

   initial begin
      int rd0;
      bus.nic_irq      = '0;
      bus.nic_data_in  = '0;
      bus3.nic_irq     = '0;
      bus3.nic_data_in = '0;

      // Power-on reset
      tick(3);
      chk_all_zero("por");
      rst_n = 1'b1;
      tick(2);

      // Reset asserted mid-gap with a second byte still queued
      do_send(1'b0, 8'h55);
      do_send(1'b0, 8'h66);
      tick(6);
      chk("pre_rst_nwr", 32'(wr_cyc.size()), 1);
      if (wr_dat.size() > 0) chk("pre_rst_dat", 32'(wr_dat[0]), 32'h55);
      chk("pre_rst_txcnt", 32'(tx_count), 32'h01);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst");
      tick(2);
      rst_n = 1'b1;
      log_clear();
      tick(40);
      chk("no_wr_after_rst", 32'(wr_cyc.size()), 0);

      // Single send on ch1: write after 2 edges, ch0 untouched
      do_send(1'b1, 8'hA5);
      chk("single_early", 32'(bus.nic_write), 0);
      tick(1);
      chk("single_wr", 32'(bus.nic_write), 32'b10);
      chk("single_dat1", 32'(bus.nic_data_out[15:8]), 32'hA5);
      chk("single_dat0", 32'(bus.nic_data_out[7:0]), 0);
      tick(1);
      chk("single_wr_off", 32'(bus.nic_write), 0);
      chk("single_txcnt", 32'(tx_count), 32'h10);
      chk("single_hold", 32'(bus.nic_data_out[15:8]), 32'hA5);

      // Six back-to-back sends on ch0: only the sixth is dropped
      tick(20);
      log_clear();
      for (int j = 0; j < 6; j++) begin
         do_send(1'b0, 8'(8'h10 + j));
         chk($sformatf("burst_drop%0d", j), 32'(send_drop), (j == 5) ? 32'd1 : 32'd0);
      end
      tick(1);
      chk("burst_drop_end", 32'(send_drop), 0);
      tick(80);
      chk("burst_nwr", 32'(wr_cyc.size()), 5);
      for (int j = 0; j < 5 && j < wr_cyc.size(); j++) begin
         chk($sformatf("burst_ch%0d", j), 32'(wr_ch[j]), 0);
         chk($sformatf("burst_dat%0d", j), 32'(wr_dat[j]), 32'(8'h10 + j));
         if (j > 0) chk($sformatf("burst_gap%0d", j), 32'(wr_cyc[j] - wr_cyc[j-1]), 16);
      end
      chk("burst_txcnt", 32'(tx_count), 32'h15);

      // Out-of-range channel on the three-channel instance, then a valid one
      send3 = 1'b1; send3_ch = 2'd3;
      tick(1);
      send3 = 1'b0;
      chk("badch_drop", 32'(drop3), 1);
      tick(20);
      chk("badch_txcnt", 32'(tx_count3), 0);
      send3 = 1'b1; send3_ch = 2'd2;
      tick(1);
      send3 = 1'b0;
      chk("goodch_drop", 32'(drop3), 0);
      tick(1);
      chk("goodch_wr", 32'(bus3.nic_write), 32'b100);
      chk("goodch_dat", 32'(bus3.nic_data_out[23:16]), 32'h5A);

      // Simultaneous receive on both channels
      bus.nic_data_in = {8'h22, 8'h11};
      bus.nic_irq     = 2'b11;
      tick(1);
      bus.nic_irq     = 2'b00;
      chk("dual_read", 32'(bus.nic_read), 32'b11);
      chk("dual_rxch", 32'(last_rx_ch), 0);
      chk("dual_rxdat", 32'(last_rx_data), 32'h11);
      chk("dual_rxcnt", 32'(rx_count), 32'h11);
      tick(1);
      chk("dual_read_off", 32'(bus.nic_read), 0);
      chk("dual_rd0", 32'(rd_cnt[0]), 1);
      chk("dual_rd1", 32'(rd_cnt[1]), 1);
      chk("dual_mism", 32'(mismatch), 0);

      // Loopback check on ch1
      loopback_chk = 1'b1;
      log_clear();
      do_send(1'b1, 8'h3C);
      tick(20);
      chk("lb_nwr", 32'(wr_cyc.size()), 1);
      rx_byte(1, 8'h3C);
      chk("lb_match", 32'(mismatch), 0);
      rx_byte(1, 8'h3D);
      chk("lb_miss", 32'(mismatch), 32'b10);
      rx_byte(1, 8'h3C);
      chk("lb_sticky", 32'(mismatch), 32'b10);
      chk("lb_rxcnt", 32'(rx_count), 32'h41);
      loopback_chk = 1'b0;

      // Persistent irq on ch0: serviced every other cycle, count wraps 1+15 -> 0
      rd0 = rd_cnt[0];
      bus.nic_data_in[7:0] = 8'h9E;
      bus.nic_irq[0] = 1'b1;
      tick(30);
      bus.nic_irq[0] = 1'b0;
      tick(2);
      chk("wrap_reads", 32'(rd_cnt[0] - rd0), 15);
      chk("wrap_rxcnt", 32'(rx_count), 32'h40);
      chk("wrap_rxdat", 32'(last_rx_data), 32'h9E);
      chk("wrap_rxch", 32'(last_rx_ch), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
